// File: rtl/prog_rom_pkg.sv
// Shared definitions for the loadable program ROM: word layout, halt word,
// FSM states and a constant-width helper.
package prog_rom_pkg;

    localparam int ROM_WIDTH_DEF = 21;

    // Halt is an unconditional jump whose target field points back at itself.
    localparam logic [4:0]  OPC_JMP     = 5'b01001;
    localparam logic [15:0] HALT_TARGET = 16'h0008;
    localparam logic [20:0] HALT_WORD_DEF = {OPC_JMP, HALT_TARGET};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_rom_array.sv
// DEPTH x ROM_WIDTH storage: one synchronous write port and one registered
// read port whose output register can be forced to the halt word.
module prog_rom_array
    import prog_rom_pkg::*;
#(
    parameter int                   ROM_WIDTH = ROM_WIDTH_DEF,
    parameter int                   DEPTH     = 16,
    parameter int                   IDX_W     = 4,
    parameter logic [ROM_WIDTH-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  logic [ROM_WIDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic                 halt_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output logic [ROM_WIDTH-1:0] rdata_o
);

    logic [ROM_WIDTH-1:0] mem_q [DEPTH];
    logic [ROM_WIDTH-1:0] rdata_q;

    // Storage write; contents are only ever cleared by the INIT sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register samples the old word, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= HALT_WORD;
        end else if (re_i && halt_i) begin
            rdata_q <= HALT_WORD;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_rom_sync.sv
// Loadable synchronous instruction memory with a reset-time halt-fill sweep,
// registered reads with valid/out-of-range flags and acknowledged writes.
module prog_rom_sync
    import prog_rom_pkg::*;
#(
    parameter int                   ROM_WIDTH  = ROM_WIDTH_DEF,
    parameter int                   ADDR_WIDTH = 16,
    parameter int                   DEPTH      = 16,
    parameter logic [ROM_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ROM_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  rd_oor,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ROM_WIDTH-1:0]  wr_data,
    output logic                  wr_ack,
    output logic                  ready
);

    localparam int IDX_W = clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable; no address aliasing.
    localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 rd_valid_q, rd_oor_q, wr_ack_q, ready_q;

    logic                 run_s;
    logic                 rd_in_range_s, wr_in_range_s;
    logic                 rd_fire_s, wr_fire_s;
    logic                 mem_we_s;
    logic [IDX_W-1:0]     mem_waddr_s;
    logic [ROM_WIDTH-1:0] mem_wdata_s;

    assign run_s         = (state_q == ST_RUN);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_fire_s     = rst_n & run_s & rd_req;
    assign wr_fire_s     = rst_n & run_s & wr_en & wr_in_range_s;

    // Next state, init counter and array write-port steering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = HALT_WORD;
        case (state_q)
            ST_INIT: begin
                mem_we_s = rst_n;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = {IDX_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                mem_we_s    = wr_fire_s;
                mem_waddr_s = wr_addr[IDX_W-1:0];
                mem_wdata_s = wr_data;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, counter and handshake flags with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= {IDX_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_fire_s;
            rd_oor_q   <= rd_fire_s & ~rd_in_range_s;
            wr_ack_q   <= wr_fire_s;
            ready_q    <= (state_d == ST_RUN);
        end
    end

    prog_rom_array #(
        .ROM_WIDTH (ROM_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .HALT_WORD (HALT_WORD)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .re_i    (rd_fire_s),
        .halt_i  (~rd_in_range_s),
        .raddr_i (rd_addr[IDX_W-1:0]),
        .rdata_o (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign rd_oor   = rd_oor_q;
    assign wr_ack   = wr_ack_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_prog_rom_sync.sv
// Directed plus randomized bench for prog_rom_sync, checked against a
// cycle-level behavioural model of the memory and its handshakes.
module tb_prog_rom_sync;

    localparam int          DEPTH = 16;
    localparam logic [20:0] HALT  = 21'b010010000000000001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [20:0] rd_data;
    logic        rd_valid;
    logic        rd_oor;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [20:0] wr_data;
    logic        wr_ack;
    logic        ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [20:0] mem_m [DEPTH];
    int          init_left;
    logic [20:0] exp_data;
    logic        exp_valid, exp_oor, exp_ack, exp_ready;

    prog_rom_sync dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_oor   (rd_oor),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_data"},  32'(rd_data),  32'(exp_data));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        chk({tag, ".rd_oor"},   32'(rd_oor),   32'(exp_oor));
        chk({tag, ".wr_ack"},   32'(wr_ack),   32'(exp_ack));
        chk({tag, ".ready"},    32'(ready),    32'(exp_ready));
    endtask

    // Apply the spec rules for one clock edge using the current inputs, then advance.
    task automatic step();
        if (!rst_n) begin
            exp_data  = HALT;
            exp_valid = 1'b0;
            exp_oor   = 1'b0;
            exp_ack   = 1'b0;
            exp_ready = 1'b0;
            init_left = DEPTH;
        end else if (init_left > 0) begin
            mem_m[DEPTH - init_left] = HALT;
            init_left--;
            exp_valid = 1'b0;
            exp_oor   = 1'b0;
            exp_ack   = 1'b0;
            exp_ready = (init_left == 0);
        end else begin
            exp_valid = rd_req;
            exp_oor   = rd_req && (int'(rd_addr) >= DEPTH);
            if (rd_req) exp_data = (int'(rd_addr) < DEPTH) ? mem_m[rd_addr] : HALT;
            exp_ack = wr_en && (int'(wr_addr) < DEPTH);
            if (exp_ack) mem_m[wr_addr] = wr_data;
            exp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        int zero_ready;
        rst_n = 1'b0; rd_req = 1'b0; rd_addr = 16'h0000;
        wr_en = 1'b0; wr_addr = 16'h0000; wr_data = 21'h000000;
        init_left = DEPTH;
        step(); step();
        check_all("reset");

        // Release reset; hammer rd_req/wr_en during the sweep, which must be ignored.
        rst_n = 1'b1;
        zero_ready = (ready === 1'b0) ? 1 : 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1; rd_addr = 16'(i);
            wr_en = 1'b1; wr_addr = 16'(i); wr_data = 21'(i + 7);
            step();
            check_all("init");
            if (ready === 1'b0) zero_ready++;
        end
        chk("init_ready_cycles", 32'(zero_ready), 32'(DEPTH));
        idle();

        // Stream-read every word: all halt, back-to-back valid.
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1; rd_addr = 16'(i);
            step();
            check_all("sweep_read");
            chk("sweep_halt", 32'(rd_data), 32'(HALT));
        end
        idle(); step(); check_all("sweep_idle");

        // Load and read back.
        wr_en = 1'b1; wr_addr = 16'd3; wr_data = 21'h0ABCD;
        step(); check_all("wr3"); chk("wr3_ack", 32'(wr_ack), 32'd1);
        idle(); rd_req = 1'b1; rd_addr = 16'd3;
        step(); check_all("rd3"); chk("rd3_data", 32'(rd_data), 32'h0ABCD);

        // Same-address read and write: old word first, new word next.
        rd_req = 1'b1; rd_addr = 16'd5; wr_en = 1'b1; wr_addr = 16'd5; wr_data = 21'h00001;
        step(); check_all("rbw"); chk("rbw_old", 32'(rd_data), 32'(HALT));
        idle(); rd_req = 1'b1; rd_addr = 16'd5;
        step(); check_all("rbw_new"); chk("rbw_new_data", 32'(rd_data), 32'h00001);

        // Out-of-range reads and a dropped write.
        rd_addr = 16'h0010; step(); check_all("oor10"); chk("oor10_flag", 32'(rd_oor), 32'd1);
        rd_addr = 16'hFFFF; step(); check_all("oorFFFF"); chk("oorFFFF_data", 32'(rd_data), 32'(HALT));
        idle(); wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 21'h1FFFFF;
        step(); check_all("oor_wr"); chk("oor_wr_ack", 32'(wr_ack), 32'd0);
        idle(); rd_req = 1'b1; rd_addr = 16'h0000;
        step(); check_all("oor_rd0");
        idle(); step(); check_all("idle_hold");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rd_req = 1'($urandom); wr_en = 1'($urandom);
            rd_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
            wr_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
            wr_data = 21'($urandom);
            step(); check_all("rand");
        end

        // Load words 0..3, then reset in the middle of a write.
        idle();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 16'(i); wr_data = 21'h10000 + 21'(i);
            step(); check_all("load");
        end
        rst_n = 1'b0; wr_addr = 16'd2; wr_data = 21'h15555;
        step(); check_all("mid_rst"); chk("mid_rst_ready", 32'(ready), 32'd0);
        rst_n = 1'b1; idle();
        for (int i = 0; i < DEPTH; i++) begin
            step(); check_all("reinit");
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1; rd_addr = 16'(i);
            step(); check_all("reinit_read");
            chk("reinit_halt", 32'(rd_data), 32'(HALT));
        end
        idle(); step(); check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_rom_sync.md
Name: prog_rom_sync

Overview:
- Parametrised, synchronous, loadable instruction memory. Next generation of the processor's fixed case-based program ROM.
- Sits between the PC/fetch stage and the instruction decoder.
- Adds a registered read with valid handshake, a run-time program-load port, and out-of-range detection.
- Adds a reset-time init sweep that fills every word with a safe "halt" instruction.

Parameters:
- ROM_WIDTH, 21, instruction word width in bits.
- ADDR_WIDTH, 16, fetch address width (PC width).
- DEPTH, 16, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
- HALT_WORD, 21'b010010000000000001000, fill and out-of-range word (jump-to-self halt).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rd_req  in  1  fetch request, sampled each cycle.
- rd_addr  in  ADDR_WIDTH  fetch address.
- rd_data  out  ROM_WIDTH  registered instruction word.
- rd_valid  out  1  rd_data valid this cycle.
- rd_oor  out  1  with rd_valid: address was >= DEPTH.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_WIDTH  load address.
- wr_data  in  ROM_WIDTH  load word.
- wr_ack  out  1  write committed (pulse, one cycle after accepted wr_en).
- ready  out  1  block is in RUN; low during the init sweep.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk resets the block.
- Reset values: rd_data=HALT_WORD, rd_valid=0, rd_oor=0, wr_ack=0, ready=0, init counter=0, state=INIT.
- FSM has two states, INIT and RUN.
- INIT:
  - Writes HALT_WORD to word[cnt] each cycle, cnt = 0..DEPTH-1.
  - Moves to RUN on the cycle after cnt == DEPTH-1 is written, so the sweep takes exactly DEPTH cycles after reset release.
  - rd_req and wr_en are ignored: no rd_valid, no wr_ack.
  - ready=0.
- RUN:
  - ready=1. The FSM stays in RUN until reset.
- Read, latency 1:
  - rd_req=1 at edge N gives rd_valid=1 at N+1.
  - rd_data = word[rd_addr] if rd_addr < DEPTH, else HALT_WORD with rd_oor=1.
  - With rd_req=0, rd_valid=0 next cycle and rd_data holds its last value. rd_oor=0 whenever rd_valid=0.
  - Back-to-back reads: full throughput, one per cycle.
- Write:
  - wr_en=1 in RUN with wr_addr < DEPTH: word[wr_addr] <= wr_data at that edge, and wr_ack=1 the next cycle.
  - wr_addr >= DEPTH: no storage change, wr_ack stays 0 (write dropped).
- Same-cycle read and write to the same address: read-before-write. rd_data returns the old word; the new word is visible from the next read.
- Index width is clog2(DEPTH). The address compare uses the full ADDR_WIDTH, so there is no aliasing/wrap of high addresses into low words.
- Reset asserted mid-operation (any state, including mid-INIT or a pending wr_ack):
  - All outputs return to reset values next edge.
  - Any write on that edge is discarded.
  - The INIT sweep restarts from 0, so previously loaded contents are overwritten with HALT_WORD.
- Storage is plain registers/distributed RAM. There is no reset of the array other than via the INIT sweep.

Decomposition:
- Shared package prog_rom_pkg holds:
  - the ROM_WIDTH default,
  - the HALT_WORD constant plus opcode field constants used to build it,
  - the FSM state enum (ST_INIT, ST_RUN),
  - a clog2 helper function.
- One sub-module, prog_rom_array: DEPTH x ROM_WIDTH storage with one synchronous write port and one registered read port. The top holds the FSM, init counter, range checks, and handshake flags.

Test Plan:
- Release reset with DEPTH=16 → ready=0 for exactly 16 cycles, then 1. A subsequent read of every address 0..15 returns 21'b010010000000000001000 with rd_valid=1 one cycle after each rd_req and rd_oor=0.
- In RUN, write addr 3 = 21'h0ABCD → wr_ack=1 next cycle. rd_req addr 3 → rd_data=21'h0ABCD one cycle later.
- Same cycle wr_en addr 5 = 21'h00001 and rd_req addr 5 → rd_data=HALT_WORD. Next read of 5 → 21'h00001.
- rd_req addr 16'h0010 and addr 16'hFFFF → rd_valid=1, rd_oor=1, rd_data=HALT_WORD. wr_en to 16'h0010 → no wr_ack, and a read of addr 0 is unchanged.
- Load words 0..3, then pulse rst_n=0 for one cycle mid-write → wr_ack stays 0, ready drops. After 16 cycles all words read back HALT_WORD.
- Streaming rd_req for 8 consecutive cycles on addresses 0..7 → rd_valid high 8 consecutive cycles, data in order with 1-cycle latency. rd_req and wr_en during INIT → no rd_valid, no wr_ack.
